// File: rtl/joydb_serial_reader.sv
// Serial reader for DB9/JAMMA shift-register adapters.
// Clocks out NBITS bits per frame and glitch-filters the inverted result.
module joydb_serial_reader #(
  parameter int CLK_DIV = 8,
  parameter int NBITS   = 24
) (
  input  logic             clk_sys,
  input  logic             reset,
  output logic             joy_clk,
  output logic             joy_load,
  input  logic             joy_data,
  output logic             joy_select,
  output logic [NBITS-1:0] data_out,
  output logic             data_valid
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (NBITS > 2) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    LOAD,
    SETTLE,
    SAMPLE,
    CLKHI,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    tick_cnt;
  logic             tick;
  logic             sample_en;
  logic [BW-1:0]    bitcnt;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] last_frame;
  logic [NBITS-1:0] candidate;

  assign tick       = (tick_cnt == CW'(CLK_DIV - 1));
  assign sample_en  = tick && (state == SAMPLE);
  assign candidate  = ~shreg;
  assign joy_select = 1'b1;

  // Free-running divider; the FSM never stalls it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= LOAD;
      bitcnt     <= '0;
      shreg      <= '0;
      last_frame <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      joy_clk    <= 1'b0;
      joy_load   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        LOAD: begin
          if (tick) begin
            joy_load <= 1'b1;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (tick) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (tick) begin
            shreg   <= {shreg[NBITS-2:0], joy_data};
            joy_clk <= 1'b1;
            state   <= CLKHI;
          end
        end
        CLKHI: begin
          if (tick) begin
            joy_clk <= 1'b0;
            if (bitcnt == BW'(NBITS - 1)) begin
              state <= DONE;
            end else begin
              bitcnt <= bitcnt + BW'(1);
              state  <= SAMPLE;
            end
          end
        end
        DONE: begin
          // Accept a frame only when it repeats the previous one.
          if (candidate == last_frame) begin
            data_out <= candidate;
          end
          last_frame <= candidate;
          data_valid <= 1'b1;
          bitcnt     <= '0;
          joy_load   <= 1'b0;
          state      <= LOAD;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_joydb_serial_reader.sv
// Bench for joydb_serial_reader: adapter model, frame-level
// scoreboard, protocol checks and a small-parameter timing instance.
module tb_joydb_serial_reader;

  localparam int D   = 8;
  localparam int N   = 24;
  localparam int PER = (2 + 2 * N) * D;

  logic         clk_sys = 1'b0;
  logic         reset = 1'b1;
  logic         joy_clk, joy_load, joy_data, joy_select;
  logic [N-1:0] data_out;
  logic         data_valid;

  logic         t_clk, t_load, t_select, t_valid;
  logic [3:0]   t_dout;

  joydb_serial_reader #(.CLK_DIV(D), .NBITS(N)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joy_data   (joy_data),
    .joy_select (joy_select),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  joydb_serial_reader #(.CLK_DIV(2), .NBITS(4)) u_t (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy_clk    (t_clk),
    .joy_load   (t_load),
    .joy_data   (1'b1),
    .joy_select (t_select),
    .data_out   (t_dout),
    .data_valid (t_valid)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] wire_word = '1;
  logic [N-1:0] sr = '1;
  logic [N-1:0] frame_word = '1;
  logic [N-1:0] m_out = '0;
  logic [N-1:0] m_last = '0;
  logic [N-1:0] cand;
  logic [N-1:0] p_shreg = '0;
  logic         p_se = 1'b0;
  logic         pclk = 1'b0;
  logic         rst_q = 1'b1;
  logic         have_prev = 1'b0;
  logic         bit23_seen = 1'b0;
  int           edges = 0;
  int           since = 0;

  int   t_since = 0, t_lowrun = 0, t_hirun = 0, t_edges = 0;
  logic t_prev = 1'b0, t_loadok = 1'b0, t_pclk = 1'b0, t_pload = 1'b0;

  assign joy_data = sr[N-1];

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk_sys) rst_q <= reset;

  // Main instance: scoreboard, protocol checks, then adapter model.
  always @(negedge clk_sys) begin
    chk(joy_select == 1'b1, "joy_select", 32'(joy_select), 1);
    if (rst_q) begin
      m_out = '0;
      m_last = '0;
      have_prev = 1'b0;
      edges = 0;
      since = 0;
      chk(data_out == '0 && !data_valid && !joy_clk && !joy_load,
          "reset_outputs",
          {5'd0, data_valid, joy_clk, joy_load, data_out}, 0);
    end else begin
      since++;
      if (joy_clk && !pclk) edges++;
      chk(!(joy_clk && !joy_load), "clk_while_load_low",
          {joy_clk, joy_load}, 0);
      if (data_valid) begin
        cand = ~frame_word;
        if (cand == m_last) m_out = cand;
        m_last = cand;
        chk(edges == N, "edges_per_frame", edges, N);
        if (have_prev) chk(since == PER, "frame_period", since, PER);
        have_prev = 1'b1;
        since = 0;
        edges = 0;
      end
      chk(data_out == m_out, "data_out", 32'(data_out), 32'(m_out));
      if (data_out[N-1]) bit23_seen = 1'b1;
    end
    chk(int'(dut.bitcnt) <= N - 1, "bitcnt_range",
        32'(dut.bitcnt), N - 1);
    if (!rst_q && dut.shreg != p_shreg)
      chk(p_se, "sample_outside_sample_tick", 32'(dut.shreg), 32'(p_shreg));
    if (dut.sample_en)
      chk(!joy_clk && joy_load, "sample_line_state",
          {joy_clk, joy_load}, 1);
    p_shreg = dut.shreg;
    p_se = dut.sample_en;
    if (!joy_load) begin
      sr = wire_word;
      frame_word = wire_word;
    end else if (joy_clk && !pclk) begin
      sr = sr << 1;
    end
    pclk = joy_clk;
  end

  // Timing instance: CLK_DIV=2, NBITS=4, idle adapter.
  always @(negedge clk_sys) begin
    if (rst_q) begin
      t_since = 0;
      t_lowrun = 0;
      t_hirun = 0;
      t_edges = 0;
      t_prev = 1'b0;
      t_loadok = 1'b0;
      t_pclk = 1'b0;
      t_pload = 1'b0;
      chk(t_dout == '0 && !t_valid && !t_clk && !t_load && t_select,
          "t_reset_outputs", {t_select, t_valid, t_clk, t_load, t_dout}, 8'h80);
    end else begin
      t_since++;
      if (!t_load) begin
        t_lowrun++;
      end else if (!t_pload) begin
        if (t_loadok) chk(t_lowrun == 1, "t_load_low_len", t_lowrun, 1);
        t_loadok = 1'b1;
        t_lowrun = 0;
      end
      if (t_clk) begin
        t_hirun++;
        if (!t_pclk) t_edges++;
      end else if (t_pclk) begin
        chk(t_hirun == 2, "t_clk_high_len", t_hirun, 2);
        t_hirun = 0;
      end
      chk(!(t_clk && !t_load), "t_clk_while_load_low", {t_clk, t_load}, 0);
      if (t_valid) begin
        chk(t_edges == 4, "t_edges_per_frame", t_edges, 4);
        if (t_prev) chk(t_since == 20, "t_frame_period", t_since, 20);
        t_prev = 1'b1;
        t_since = 0;
        t_edges = 0;
      end
      chk(t_dout == '0 && t_select, "t_data_out", {t_select, t_dout}, 32'h10);
      t_pclk = t_clk;
      t_pload = t_load;
    end
  end

  task automatic wait_pulse();
    for (int i = 0; i < PER + 50; i++) begin
      @(posedge clk_sys);
      #1;
      if (data_valid) return;
    end
    chk(1'b0, "pulse_timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;

    // Idle: nothing pressed.
    repeat (3) wait_pulse();
    chk(data_out == '0, "idle_data_out", 32'(data_out), 0);

    // Pattern on the wire, inverted on the output after two frames.
    wire_word = 24'h5A3C0F;
    repeat (3) wait_pulse();
    chk(data_out == 24'hA5C3F0, "pattern_data_out", 32'(data_out), 32'hA5C3F0);

    // Reset during the tenth bit.
    for (int i = 0; i < 2 * PER; i++) begin
      @(posedge clk_sys);
      #1;
      if (edges == 9) break;
    end
    chk(edges == 9, "reach_bit10", edges, 9);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    chk(data_out == '0 && !joy_clk && !joy_load && !data_valid,
        "midframe_reset", {data_valid, joy_clk, joy_load, data_out}, 0);
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    wait_pulse();
    chk(data_out == '0, "first_frame_after_reset", 32'(data_out), 0);
    wait_pulse();
    chk(data_out == 24'hA5C3F0, "second_frame_after_reset",
        32'(data_out), 32'hA5C3F0);

    // Glitch: one frame with bit 23 flipped must be filtered out.
    wire_word = 24'hFFFFFE;
    repeat (3) wait_pulse();
    chk(data_out == 24'h000001, "stable_bit0", 32'(data_out), 1);
    bit23_seen = 1'b0;
    wire_word = 24'h7FFFFE;
    wait_pulse();
    wire_word = 24'hFFFFFE;
    repeat (3) wait_pulse();
    chk(data_out == 24'h000001, "after_glitch", 32'(data_out), 1);
    chk(!bit23_seen, "glitch_never_shown", 32'(bit23_seen), 0);

    repeat (5) @(posedge clk_sys);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
